emu_ckpt_ctrl: RTL and testbench

//  Checkpoint sequencer sitting directly upstream of EMU_DUT scan ports. On a dump/restore command it pauses the DUT,

---
 rtl/emu_ckpt_ctrl_if.sv | 28 ++
 rtl/emu_ckpt_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_emu_ckpt_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/emu_ckpt_ctrl_if.sv
// emu_ckpt_ctrl_if: command and dump/restore stream handshakes of the checkpoint sequencer.
//   cmd_valid/cmd_ready/cmd_restore : operation request (0 = dump, 1 = restore)
//   out_valid/out_ready/out_data    : dump stream, sequencer -> host
//   in_valid/in_ready/in_data       : restore stream, host -> sequencer
// master = host side, slave = sequencer side.
interface emu_ckpt_ctrl_if #(
    parameter int unsigned DW = 64
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_restore;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    modport master (
        output cmd_valid, cmd_restore, out_ready, in_valid, in_data,
        input  cmd_ready, out_valid, out_data, in_ready
    );

    modport slave (
        input  cmd_valid, cmd_restore, out_ready, in_valid, in_data,
        output cmd_ready, out_valid, out_data, in_ready
    );
endinterface

// File: rtl/emu_ckpt_ctrl.sv
// emu_ckpt_ctrl: checkpoint sequencer in front of the EMU_DUT scan ports. A dump pauses the
// DUT, shifts the FF chain (looped back) and then the RAM chain out over the dump stream; a
// restore shifts stream words into both chains. Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : command, dump stream and restore stream handshakes
//   busy_o, done_o  : operation in progress / one-cycle completion pulse (registered)
//   pause_o         : DUT clock-gate disable (registered)
//   ff_se_o, ff_dir_o, ff_sdi_o, ff_sdo_i     : FF scan chain control and data
//   ram_se_o, ram_sd_o, ram_sdi_o, ram_sdo_i  : RAM scan chain control and data
// Scan enables, stream valid/ready and scan data are combinational from state and handshake.
module emu_ckpt_ctrl #(
    parameter int unsigned DW        = 64,
    parameter int unsigned FF_WORDS  = 4,
    parameter int unsigned RAM_WORDS = 16,
    parameter int unsigned RAM_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    emu_ckpt_ctrl_if.slave    bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              pause_o,
    output logic              ff_se_o,
    output logic              ff_dir_o,
    output logic [DW-1:0]     ff_sdi_o,
    input  logic [DW-1:0]     ff_sdo_i,
    output logic              ram_se_o,
    output logic              ram_sd_o,
    output logic [DW-1:0]     ram_sdi_o,
    input  logic [DW-1:0]     ram_sdo_i
);
    localparam int unsigned MAX_FR = (FF_WORDS > RAM_WORDS) ? FF_WORDS : RAM_WORDS;
    localparam int unsigned MAX_N  = (MAX_FR > RAM_LAT) ? MAX_FR : RAM_LAT;
    localparam int unsigned CW     = $clog2(MAX_N + 1);

    localparam logic [CW-1:0] FF_LAST  = CW'(FF_WORDS - 1);
    localparam logic [CW-1:0] RAM_LAST = CW'(RAM_WORDS - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(RAM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_FF_XFER,
        S_RAM_PRIME,
        S_RAM_XFER,
        S_RAM_FLUSH,
        S_RESUME
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            restore_q, restore_d;
    logic            pause_q, busy_q, done_q;
    logic            fire;

    // State, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            restore_q <= 1'b0;
            pause_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            restore_q <= restore_d;
            pause_q   <= (state_d != S_IDLE);
            busy_q    <= (state_d != S_IDLE);
            // RESUME always returns to IDLE, so this marks the first IDLE cycle.
            done_q    <= (state_q == S_RESUME);
        end
    end

    // Next state, counters and combinational scan/stream controls.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        restore_d     = restore_q;
        fire          = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.in_ready  = 1'b0;
        ff_se_o       = 1'b0;
        ff_dir_o      = 1'b0;
        ff_sdi_o      = '0;
        ram_se_o      = 1'b0;
        ram_sd_o      = 1'b0;
        ram_sdi_o     = '0;

        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    restore_d = bus.cmd_restore;
                    cnt_d     = '0;
                    state_d   = S_PAUSE;
                end
            end
            S_PAUSE: begin
                cnt_d   = '0;
                state_d = S_FF_XFER;
            end
            S_FF_XFER: begin
                if (restore_q) begin
                    bus.in_ready = 1'b1;
                    ff_dir_o     = 1'b1;
                    ff_sdi_o     = bus.in_data;
                    ff_se_o      = bus.in_valid;
                    fire         = bus.in_valid;
                end else begin
                    // Dump loops the head word back so the FF chain is preserved.
                    bus.out_valid = 1'b1;
                    bus.out_data  = ff_sdo_i;
                    ff_se_o       = bus.out_ready;
                    fire          = bus.out_ready;
                end
                if (fire) begin
                    if (cnt_q == FF_LAST) begin
                        cnt_d   = '0;
                        state_d = restore_q ? S_RAM_XFER : S_RAM_PRIME;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RAM_PRIME: begin
                // Fill the RAM read pipeline before the first word is valid.
                ram_se_o = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RAM_XFER;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RAM_XFER: begin
                if (restore_q) begin
                    bus.in_ready = 1'b1;
                    ram_sd_o     = 1'b1;
                    ram_sdi_o    = bus.in_data;
                    ram_se_o     = bus.in_valid;
                    fire         = bus.in_valid;
                end else begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = ram_sdo_i;
                    ram_se_o      = bus.out_ready;
                    fire          = bus.out_ready;
                end
                if (fire) begin
                    if (cnt_q == RAM_LAST) begin
                        cnt_d   = '0;
                        state_d = restore_q ? S_RAM_FLUSH : S_RESUME;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RAM_FLUSH: begin
                // One extra load shift commits the last restored word.
                ram_se_o = 1'b1;
                ram_sd_o = 1'b1;
                cnt_d    = '0;
                state_d  = S_RESUME;
            end
            S_RESUME: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign pause_o = pause_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
endmodule

// File: tb/tb_emu_ckpt_ctrl.sv
// Bench for emu_ckpt_ctrl with a behavioural FF/RAM scan-chain target.
module tb_emu_ckpt_ctrl;
    localparam int unsigned DW  = 64;
    localparam int unsigned FFW = 2;
    localparam int unsigned RW  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned NW  = FFW + RW;

    typedef logic [DW-1:0] words_t [NW];

    typedef struct {
        logic restore;
        int   mode;
        int   exp_ff_se;
        int   exp_ram_se;
        int   exp_fires;
        int   exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    emu_ckpt_ctrl_if #(.DW(DW)) bus ();

    logic          busy, done, pause, ff_se, ff_dir, ram_se, ram_sd;
    logic [DW-1:0] ff_sdi, ff_sdo, ram_sdi, ram_sdo;

    emu_ckpt_ctrl #(.DW(DW), .FF_WORDS(FFW), .RAM_WORDS(RW), .RAM_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy_o   (busy),
        .done_o   (done),
        .pause_o  (pause),
        .ff_se_o  (ff_se),
        .ff_dir_o (ff_dir),
        .ff_sdi_o (ff_sdi),
        .ff_sdo_i (ff_sdo),
        .ram_se_o (ram_se),
        .ram_sd_o (ram_sd),
        .ram_sdi_o(ram_sdi),
        .ram_sdo_i(ram_sdo)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- scan-chain target model ----------------
    logic [DW-1:0] ff_chain [FFW];
    logic [DW-1:0] mem      [RW];
    logic [DW-1:0] rd_pipe  [LAT];
    logic [DW-1:0] pl_ff    [FFW];
    logic [DW-1:0] pl_mem   [RW];
    logic [DW-1:0] wr_hold;
    logic          wr_hold_v;
    int            rd_ptr, wr_ptr;
    logic          preload;

    assign ff_sdo  = ff_chain[0];
    assign ram_sdo = rd_pipe[0];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < FFW; i++) ff_chain[i] <= pl_ff[i];
            for (int i = 0; i < RW; i++)  mem[i]      <= pl_mem[i];
        end else begin
            if (ff_se) begin
                for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i+1];
                ff_chain[FFW-1] <= ff_dir ? ff_sdi : ff_chain[0];
            end
            if (!pause) begin
                rd_ptr    <= 0;
                wr_ptr    <= 0;
                wr_hold_v <= 1'b0;
            end else if (ram_se && !ram_sd) begin
                for (int i = 0; i < LAT - 1; i++) rd_pipe[i] <= rd_pipe[i+1];
                rd_pipe[LAT-1] <= mem[rd_ptr % RW];
                rd_ptr <= rd_ptr + 1;
            end else if (ram_se && ram_sd) begin
                if (wr_hold_v) begin
                    mem[wr_ptr % RW] <= wr_hold;
                    wr_ptr <= wr_ptr + 1;
                end
                wr_hold   <= ram_sdi;
                wr_hold_v <= 1'b1;
            end
        end
    end

    // ---------------- handshake driver ----------------
    int            hs_mode;
    int            win_k;
    int            n_in;
    logic          drv_r;
    words_t        send_words;

    always begin
        @(negedge clk);
        case (hs_mode)
            0:       drv_r = 1'b1;
            1:       drv_r = (win_k % 2 == 0);
            2:       drv_r = (win_k % 3 == 0);
            default: drv_r = 1'($urandom_range(1, 0));
        endcase
        bus.out_ready = drv_r;
        bus.in_valid  = drv_r;
        bus.in_data   = send_words[n_in % NW];
    end

    // ---------------- monitor (samples mid-low-phase) ----------------
    logic          mon_clr;
    int            n_ff_se, n_ram_se, n_both, n_busy, n_done, n_pause_done;
    int            n_cmd, n_rdy_busy, n_hold_bad;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] words_q [$];

    always begin
        @(negedge clk);
        #4;
        if (mon_clr) begin
            n_ff_se = 0; n_ram_se = 0; n_both = 0; n_busy = 0; n_done = 0;
            n_pause_done = 0; n_cmd = 0; n_rdy_busy = 0; n_hold_bad = 0;
            win_k = 0; n_in = 0; prev_stall = 1'b0; prev_data = '0;
            words_q.delete();
        end else begin
            if (ff_se === 1'b1) n_ff_se++;
            if (ram_se === 1'b1) n_ram_se++;
            if (ff_se === 1'b1 && ram_se === 1'b1) n_both++;
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin
                n_done++;
                if (pause !== 1'b0) n_pause_done++;
            end
            if (bus.cmd_valid && bus.cmd_ready) n_cmd++;
            if (bus.cmd_ready && busy) n_rdy_busy++;
            if (bus.out_valid || bus.in_ready) win_k++;
            if (bus.out_valid && bus.out_ready) words_q.push_back(bus.out_data);
            if (bus.in_valid && bus.in_ready) n_in++;
            if (prev_stall && bus.out_valid && bus.out_data !== prev_data) n_hold_bad++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    words_t exp_words;

    // Load random chain contents; optionally make them the expected dump image.
    task automatic preload_random(input bit set_exp);
        for (int i = 0; i < FFW; i++) begin
            pl_ff[i] = rand64();
            if (set_exp) exp_words[i] = pl_ff[i];
        end
        for (int i = 0; i < RW; i++) begin
            pl_mem[i] = rand64();
            if (set_exp) exp_words[FFW+i] = pl_mem[i];
        end
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
    endtask

    task automatic run_op(input logic restore);
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_restore = restore;
        @(negedge clk); bus.cmd_valid = 1'b0;
        for (int c = 0; c < 400 && n_done == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_stream(input string nm, input words_t e);
        for (int i = 0; i < NW; i++)
            chk(nm, (i < words_q.size()) ? words_q[i] : 'x, e[i]);
    endtask

    task automatic chk_chain(input string nm, input words_t e);
        for (int i = 0; i < FFW; i++) chk({nm, "_ff"}, ff_chain[i], e[i]);
        for (int i = 0; i < RW; i++)  chk({nm, "_mem"}, mem[i], e[FFW+i]);
    endtask

    task automatic chk_common(input string nm);
        chk({nm, "_done_cnt"}, 64'(n_done), 64'd1);
        chk({nm, "_both_se"}, 64'(n_both), 64'd0);
        chk({nm, "_pause_at_done"}, 64'(n_pause_done), 64'd0);
        chk({nm, "_ready_busy"}, 64'(n_rdy_busy), 64'd0);
    endtask

    vec_t   tbl [6];
    words_t dumped;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{restore: 1'b0, mode: 0, exp_ff_se: 2, exp_ram_se: 6, exp_fires: 6, exp_busy: 10};
        tbl[1] = '{restore: 1'b0, mode: 1, exp_ff_se: 2, exp_ram_se: 6, exp_fires: 6, exp_busy: 15};
        tbl[2] = '{restore: 1'b0, mode: 2, exp_ff_se: 2, exp_ram_se: 6, exp_fires: 6, exp_busy: 20};
        tbl[3] = '{restore: 1'b1, mode: 0, exp_ff_se: 2, exp_ram_se: 5, exp_fires: 6, exp_busy: 9};
        tbl[4] = '{restore: 1'b1, mode: 1, exp_ff_se: 2, exp_ram_se: 5, exp_fires: 6, exp_busy: 14};
        tbl[5] = '{restore: 1'b1, mode: 2, exp_ff_se: 2, exp_ram_se: 5, exp_fires: 6, exp_busy: 19};

        rst = 1'b1; preload = 1'b0; mon_clr = 1'b1; hs_mode = 0;
        bus.cmd_valid = 1'b0; bus.cmd_restore = 1'b0;
        for (int i = 0; i < NW; i++) send_words[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pause", pause, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_se", {ff_se, ram_se, ff_dir, ram_sd}, 0);
        chk("rst_stream", {bus.out_valid, bus.in_ready, bus.cmd_ready}, 64'b001);
        chk("rst_sdi", ff_sdi | ram_sdi, 0);
        rst = 1'b0;

        // Scenario: cycle timing of a dump with the stream always ready
        preload_random(1'b1);
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
        #1;
        chk("t0_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_restore = 1'b0;
        @(negedge clk); bus.cmd_valid = 1'b0;
        #1;
        chk("t1_pause_busy_rdy", {pause, busy, bus.cmd_ready}, 64'b110);
        for (int c = 0; c < 100 && done !== 1'b1; c++) begin @(negedge clk); #1; end
        chk("done_cycle_state", {done, pause, busy, bus.cmd_ready}, 64'b1001);
        @(negedge clk); #1;
        chk("done_one_pulse", done, 0);
        chk_stream("timing_dump_word", exp_words);

        // Table-driven operations over handshake gap patterns
        for (int t = 0; t < 6; t++) begin
            hs_mode = tbl[t].mode;
            preload_random(1'b1);
            for (int i = 0; i < NW; i++) send_words[i] = rand64();
            run_op(tbl[t].restore);
            chk("tbl_ff_se", 64'(n_ff_se), 64'(tbl[t].exp_ff_se));
            chk("tbl_ram_se", 64'(n_ram_se), 64'(tbl[t].exp_ram_se));
            chk("tbl_busy_cycles", 64'(n_busy), 64'(tbl[t].exp_busy));
            chk("tbl_fires", tbl[t].restore ? 64'(n_in) : 64'(words_q.size()),
                64'(tbl[t].exp_fires));
            chk("tbl_hold", 64'(n_hold_bad), 64'd0);
            chk_common("tbl");
            if (tbl[t].restore) chk_chain("tbl_restore", send_words);
            else                chk_stream("tbl_dump_word", exp_words);
        end

        // Random round trips: dump, scramble, restore the dumped image
        for (int r = 0; r < 4; r++) begin
            hs_mode = 3;
            preload_random(1'b1);
            run_op(1'b0);
            chk_stream("rt_dump_word", exp_words);
            chk("rt_dump_ram_se", 64'(n_ram_se), 64'(LAT + RW));
            chk("rt_hold", 64'(n_hold_bad), 64'd0);
            chk_common("rt_dump");
            for (int i = 0; i < NW; i++) dumped[i] = (i < words_q.size()) ? words_q[i] : '0;
            for (int i = 0; i < NW; i++) send_words[i] = dumped[i];
            preload_random(1'b0);
            run_op(1'b1);
            chk("rt_restore_ram_se", 64'(n_ram_se), 64'(RW + 1));
            chk_common("rt_restore");
            chk_chain("rt_restore", exp_words);
        end

        // Reset during RAM transfer, then a normal operation
        hs_mode = 0;
        preload_random(1'b1);
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_restore = 1'b0;
        @(negedge clk); bus.cmd_valid = 1'b0;
        #1;
        begin
            int c;
            c = 0;
            while (c < 100 && !(ram_se === 1'b1 && bus.out_valid === 1'b1)) begin
                @(negedge clk); #1; c++;
            end
            chk("mid_reach_ram_xfer", 64'(c < 100), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_state", {pause, busy, done, ff_se, ram_se, bus.cmd_ready}, 64'b000001);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_done", 64'(n_done), 64'd0);
        preload_random(1'b1);
        run_op(1'b0);
        chk("post_rst_busy", 64'(n_busy), 64'd10);
        chk_common("post_rst");
        chk_stream("post_rst_word", exp_words);

        // cmd_valid held high: one operation, second accepted only at done
        preload_random(1'b1);
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_restore = 1'b0;
        for (int c = 0; c < 100 && n_done == 0; c++) @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("held_cmd_fires_at_done", 64'(n_cmd), 64'd2);
        chk("held_ready_busy", 64'(n_rdy_busy), 64'd0);
        for (int c = 0; c < 100 && n_done < 2; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("held_two_done", 64'(n_done), 64'd2);
        chk("held_words", 64'(words_q.size()), 64'(2 * NW));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
